// File: rtl/gameover_anim_ctrl.sv
// Game-over animation controller.
// When a player loses, that player's screen strip blinks a checkerboard,
// then scrolls the checkerboard horizontally, and finally shows a solid
// strip until a restart request arrives. The pixel outputs are registered
// one clock after xpix/ypix.
module gameover_anim_ctrl #(
  parameter int NPLAYERS      = 2,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int TILE_LOG2     = 5,
  parameter int BLINK_PERIOD  = 8,
  parameter int BLINK_TOGGLES = 6,
  parameter int HOLD_FRAMES   = 120
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic [NPLAYERS-1:0] loss,
  input  logic                restart,
  input  logic [9:0]          xpix,
  input  logic [9:0]          ypix,
  output logic                pixval,
  output logic                altcolor,
  output logic                active,
  output logic                done,
  output logic [1:0]          loser
);

  localparam int CNT_MAX = (BLINK_PERIOD > HOLD_FRAMES) ? BLINK_PERIOD : HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TGL_W   = $clog2(BLINK_TOGGLES + 1);
  localparam int OFS_W   = TILE_LOG2 + 1;
  localparam int STRIP_W = H_RES / NPLAYERS;

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [TGL_W-1:0] TGL_LAST   = TGL_W'(BLINK_TOGGLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLINK,
    SCROLL,
    DONE
  } state_t;

  state_t           state_q;
  logic [1:0]       loser_q;
  logic             blink_on_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [TGL_W-1:0] toggle_cnt_q;
  logic [OFS_W-1:0] offset_q;
  logic             active_q;
  logic             done_q;
  logic             pixval_q;
  logic             altcolor_q;

  logic             any_loss;
  logic [1:0]       first_loser;
  logic [10:0]      x_ext;
  logic             in_range;
  logic             in_strips;
  logic [1:0]       strip_idx;
  logic             in_loser;
  logic [OFS_W-1:0] ofs_eff;
  logic             chk;
  logic             pixval_d;
  logic             altcolor_d;

  assign pixval   = pixval_q;
  assign altcolor = altcolor_q;
  assign active   = active_q;
  assign done     = done_q;
  assign loser    = loser_q;

  // Lowest-index set loss bit wins when several players lose together.
  always_comb begin
    any_loss    = |loss;
    first_loser = '0;
    for (int unsigned i = NPLAYERS; i > 0; i--) begin
      if (loss[i-1]) first_loser = 2'(i - 1);
    end
  end

  // Strip membership, checkerboard bit and per-state pixel pattern.
  always_comb begin
    x_ext     = {1'b0, xpix};
    in_range  = (x_ext < 11'(H_RES)) && ({1'b0, ypix} < 11'(V_RES));
    in_strips = x_ext < 11'(NPLAYERS * STRIP_W);
    strip_idx = '0;
    for (int unsigned k = 1; k < NPLAYERS; k++) begin
      if (x_ext >= 11'(k * STRIP_W)) strip_idx = 2'(k);
    end
    in_loser = in_range && in_strips && (strip_idx == loser_q);
    ofs_eff  = (state_q == SCROLL) ? offset_q : '0;
    // Sum is formed in 11 bits so a carry out of xpix still reaches the tile bit.
    chk      = ((((x_ext + 11'(ofs_eff)) >> TILE_LOG2) & 11'd1) != 11'd0) ^ ypix[TILE_LOG2];
    pixval_d   = 1'b0;
    altcolor_d = 1'b0;
    case (state_q)
      BLINK: begin
        pixval_d   = in_loser & blink_on_q & chk;
        altcolor_d = pixval_d;
      end
      SCROLL: begin
        pixval_d   = in_loser & chk;
        altcolor_d = pixval_d;
      end
      DONE: begin
        pixval_d   = in_loser;
        altcolor_d = 1'b0;
      end
      default: begin
        pixval_d   = 1'b0;
        altcolor_d = 1'b0;
      end
    endcase
  end

  // Animation FSM with registered status and pixel outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      loser_q      <= '0;
      blink_on_q   <= 1'b0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      offset_q     <= '0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      pixval_q     <= 1'b0;
      altcolor_q   <= 1'b0;
    end else begin
      pixval_q   <= pixval_d;
      altcolor_q <= altcolor_d;
      case (state_q)
        IDLE: begin
          // A frame_tick on this edge is deliberately not counted.
          if (any_loss) begin
            state_q      <= BLINK;
            loser_q      <= first_loser;
            blink_on_q   <= 1'b1;
            frame_cnt_q  <= '0;
            toggle_cnt_q <= '0;
            offset_q     <= '0;
            active_q     <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        BLINK: begin
          if (frame_tick) begin
            if (frame_cnt_q == BLINK_LAST) begin
              blink_on_q  <= ~blink_on_q;
              frame_cnt_q <= '0;
              if (toggle_cnt_q == TGL_LAST) begin
                state_q      <= SCROLL;
                offset_q     <= '0;
                toggle_cnt_q <= '0;
              end else begin
                toggle_cnt_q <= toggle_cnt_q + 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        SCROLL: begin
          if (frame_tick) begin
            if (frame_cnt_q == HOLD_LAST) begin
              state_q     <= DONE;
              frame_cnt_q <= '0;
              offset_q    <= '0;
              active_q    <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              offset_q    <= offset_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (restart) begin
            state_q    <= IDLE;
            loser_q    <= '0;
            blink_on_q <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gameover_anim_ctrl.sv
// Directed testbench for gameover_anim_ctrl (2-player default and 4-player build).
module tb_gameover_anim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [1:0] loss;
  logic [3:0] loss4;
  logic       restart;
  logic [9:0] xpix;
  logic [9:0] ypix;
  logic       pixval, altcolor, active, done;
  logic [1:0] loser;
  logic       pixval4, altcolor4, active4, done4;
  logic [1:0] loser4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gameover_anim_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .loss(loss),
    .restart(restart), .xpix(xpix), .ypix(ypix), .pixval(pixval),
    .altcolor(altcolor), .active(active), .done(done), .loser(loser)
  );

  gameover_anim_ctrl #(.NPLAYERS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .loss(loss4),
    .restart(restart), .xpix(xpix), .ypix(ypix), .pixval(pixval4),
    .altcolor(altcolor4), .active(active4), .done(done4), .loser(loser4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame_tick pulse followed by an idle cycle so the pixel register
  // reflects the state updated by the tick.
  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; xpix = 10'd352; ypix = 10'd0;
    step(); step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL reset_pixval got=%b exp=0", pixval); end
    checks++; if (altcolor !== 1'b0) begin failures++; $display("FAIL reset_altcolor got=%b exp=0", altcolor); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (loser !== 2'd0) begin failures++; $display("FAIL reset_loser got=%0d exp=0", loser); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start();
    loss = 2'b10;
    step();
    loss = 2'b00;
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL start_active got=%b exp=1", active); end
    checks++; if (loser !== 2'd1) begin failures++; $display("FAIL start_loser got=%0d exp=1", loser); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL start_done got=%b exp=0", done); end
    xpix = 10'd352; ypix = 10'd0;
    step();
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL start_pix352 got=%b exp=1", pixval); end
    checks++; if (altcolor !== 1'b1) begin failures++; $display("FAIL start_alt352 got=%b exp=1", altcolor); end
    xpix = 10'd0;
    step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL start_pix0 got=%b exp=0", pixval); end
    do_reset();
  endtask

  task automatic test_priority();
    loss = 2'b11; frame_tick = 1'b1;
    step();
    loss = 2'b00; frame_tick = 1'b0;
    checks++; if (loser !== 2'd0) begin failures++; $display("FAIL prio_loser got=%0d exp=0", loser); end
    loss = 2'b10;
    step();
    loss = 2'b00;
    checks++; if (loser !== 2'd0) begin failures++; $display("FAIL prio_late_loss got=%0d exp=0", loser); end
  endtask

  task automatic test_restart_ignored();
    restart = 1'b1;
    step();
    restart = 1'b0;
    step();
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL rst_ign_active got=%b exp=1", active); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_ign_done got=%b exp=0", done); end
  endtask

  task automatic test_blink_scroll_done();
    // Probe (0,32): loser strip 0, checker bit 1, so pixval mirrors blink_on.
    xpix = 10'd0; ypix = 10'd32;
    run_frames(7);
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL blink_t7 got=%b exp=1", pixval); end
    run_frames(1);
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL blink_t8 got=%b exp=0", pixval); end
    run_frames(7);
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL blink_t15 got=%b exp=0", pixval); end
    run_frames(1);
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL blink_t16 got=%b exp=1", pixval); end
    run_frames(31);
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL blink_t47 got=%b exp=0", pixval); end
    xpix = 10'd31; ypix = 10'd0;
    run_frames(1);
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL scroll_t48_ofs0 got=%b exp=0", pixval); end
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL scroll_t48_active got=%b exp=1", active); end
    run_frames(1);
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL scroll_t49_ofs1 got=%b exp=1", pixval); end
    checks++; if (altcolor !== 1'b1) begin failures++; $display("FAIL scroll_t49_alt got=%b exp=1", altcolor); end
    run_frames(118);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL scroll_t167_done got=%b exp=0", done); end
    run_frames(1);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_t168 got=%b exp=1", done); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL done_active got=%b exp=0", active); end
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL done_solid got=%b exp=1", pixval); end
    checks++; if (altcolor !== 1'b0) begin failures++; $display("FAIL done_alt got=%b exp=0", altcolor); end
    xpix = 10'd400;
    step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL done_other_strip got=%b exp=0", pixval); end
    xpix = 10'd700; ypix = 10'd10;
    step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL oob_x got=%b exp=0", pixval); end
    xpix = 10'd10; ypix = 10'd500;
    step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL oob_y got=%b exp=0", pixval); end
    xpix = 10'd31; ypix = 10'd0;
    step();
  endtask

  task automatic test_done_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL restart_done got=%b exp=0", done); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL restart_active got=%b exp=0", active); end
    checks++; if (loser !== 2'd0) begin failures++; $display("FAIL restart_loser got=%0d exp=0", loser); end
    step();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL restart_pix got=%b exp=0", pixval); end
  endtask

  task automatic test_reset_mid_scroll();
    loss = 2'b10;
    step();
    loss = 2'b00;
    run_frames(48);
    // (320,32) with offset 5: bit5(325)=0, bit5(32)=1 -> checker 1.
    xpix = 10'd320; ypix = 10'd32;
    run_frames(5);
    checks++; if (pixval !== 1'b1) begin failures++; $display("FAIL midscroll_pix got=%b exp=1", pixval); end
    do_reset();
    checks++; if (pixval !== 1'b0) begin failures++; $display("FAIL midrst_pix got=%b exp=0", pixval); end
    checks++; if (altcolor !== 1'b0) begin failures++; $display("FAIL midrst_alt got=%b exp=0", altcolor); end
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL midrst_active got=%b exp=0", active); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (loser !== 2'd0) begin failures++; $display("FAIL midrst_loser got=%0d exp=0", loser); end
  endtask

  task automatic test_reset_release_loss();
    rst_n = 1'b0; loss = 2'b10;
    step();
    checks++; if (active !== 1'b0) begin failures++; $display("FAIL relloss_inrst got=%b exp=0", active); end
    rst_n = 1'b1;
    step();
    loss = 2'b00;
    checks++; if (active !== 1'b1) begin failures++; $display("FAIL relloss_active got=%b exp=1", active); end
    checks++; if (loser !== 2'd1) begin failures++; $display("FAIL relloss_loser got=%0d exp=1", loser); end
    do_reset();
  endtask

  task automatic test_four_players();
    loss4 = 4'b0100;
    step();
    loss4 = 4'b0000;
    checks++; if (loser4 !== 2'd2) begin failures++; $display("FAIL p4_loser got=%0d exp=2", loser4); end
    checks++; if (active4 !== 1'b1) begin failures++; $display("FAIL p4_active got=%b exp=1", active4); end
    checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL p4_done got=%b exp=0", done4); end
    xpix = 10'd320; ypix = 10'd32;
    step();
    checks++; if (pixval4 !== 1'b1) begin failures++; $display("FAIL p4_pix320 got=%b exp=1", pixval4); end
    checks++; if (altcolor4 !== 1'b1) begin failures++; $display("FAIL p4_alt320 got=%b exp=1", altcolor4); end
    xpix = 10'd479;
    step();
    checks++; if (pixval4 !== 1'b1) begin failures++; $display("FAIL p4_pix479 got=%b exp=1", pixval4); end
    xpix = 10'd480; ypix = 10'd0;
    step();
    checks++; if (pixval4 !== 1'b0) begin failures++; $display("FAIL p4_pix480 got=%b exp=0", pixval4); end
    xpix = 10'd319;
    step();
    checks++; if (pixval4 !== 1'b0) begin failures++; $display("FAIL p4_pix319 got=%b exp=0", pixval4); end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; loss = '0; loss4 = '0;
    restart = 1'b0; xpix = '0; ypix = '0;
    test_reset();
    test_start();
    test_priority();
    test_restart_ignored();
    test_blink_scroll_done();
    test_done_restart();
    test_reset_mid_scroll();
    test_reset_release_loss();
    test_four_players();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
